// File: rtl/tpl_test_pkg.sv
// Shared types and defaults for the truth-table sweep controller and its
// wrapper interface.
package tpl_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_STORE  = 3'd3,
        ST_DONE   = 3'd4
    } tpl_state_t;

    localparam int DEF_IN_WIDTH      = 4;
    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_SAMPLES       = 8;

    // One truth-table entry per possible input vector.
    function automatic int TABLE_DEPTH(input int in_width);
        return 1 << in_width;
    endfunction

endpackage

// File: rtl/tpl_sweep_ctrl_if.sv
// Bundle between the board test controller, the CUT and the sweep sequencer.
// The master side is the sequencer; the slave side is the board/CUT.
interface tpl_sweep_ctrl_if
    import tpl_test_pkg::*;
#(
    parameter int IN_WIDTH = DEF_IN_WIDTH
);
    localparam int DEPTH = TABLE_DEPTH(IN_WIDTH);

    logic                start;
    logic                dut_out;
    logic [IN_WIDTH-1:0] dut_in;
    logic                busy;
    logic                done;
    logic [DEPTH-1:0]    truth_table;
    logic [DEPTH-1:0]    unstable;

    modport master (
        input  start,
        input  dut_out,
        output dut_in,
        output busy,
        output done,
        output truth_table,
        output unstable
    );

    modport slave (
        output start,
        output dut_out,
        input  dut_in,
        input  busy,
        input  done,
        input  truth_table,
        input  unstable
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, cleared by the
// synchronous reset so no stale CUT level survives a restart.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/tpl_sweep_ctrl.sv
// Exhaustive characterisation sequencer: walks every CUT input vector, lets it
// settle, majority-votes the synchronized output and flags disagreeing samples.
module tpl_sweep_ctrl
    import tpl_test_pkg::*;
#(
    parameter int IN_WIDTH      = DEF_IN_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SAMPLES       = DEF_SAMPLES
) (
    input  logic             clk,
    input  logic             reset,
    tpl_sweep_ctrl_if.master bus
);
    localparam int DEPTH   = TABLE_DEPTH(IN_WIDTH);
    localparam int ONES_W  = $clog2(SAMPLES + 1);
    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    SAMPLE_LAST = CNT_W'(SAMPLES - 1);
    localparam logic [ONES_W-1:0]   ONES_ALL    = ONES_W'(SAMPLES);
    localparam logic [ONES_W:0]     SAMPLES_EXT = (ONES_W + 1)'(SAMPLES);
    localparam logic [IN_WIDTH-1:0] VEC_LAST    = IN_WIDTH'(DEPTH - 1);

    tpl_state_t          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ONES_W-1:0]   r_ones;
    logic [IN_WIDTH-1:0] r_vec;
    logic [IN_WIDTH-1:0] r_dut_in;
    logic                r_busy;
    logic                r_done;
    logic [DEPTH-1:0]    r_tt;
    logic [DEPTH-1:0]    r_uns;

    tpl_state_t          w_state;
    logic [CNT_W-1:0]    w_cnt;
    logic [ONES_W-1:0]   w_ones;
    logic [IN_WIDTH-1:0] w_vec;
    logic [IN_WIDTH-1:0] w_dut_in;
    logic                w_busy;
    logic                w_done;
    logic [DEPTH-1:0]    w_tt;
    logic [DEPTH-1:0]    w_uns;
    logic                w_sync;
    logic [ONES_W:0]     w_twice;
    logic                w_majority;
    logic                w_mixed;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (bus.dut_out),
        .o_q   (w_sync)
    );

    // Strict majority: a tie (exactly half ones) resolves to 0.
    assign w_twice    = {r_ones, 1'b0};
    assign w_majority = (w_twice > SAMPLES_EXT);
    assign w_mixed    = (r_ones != {ONES_W{1'b0}}) && (r_ones != ONES_ALL);

    // Next-state and next-register values for the sweep FSM.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_ones   = r_ones;
        w_vec    = r_vec;
        w_dut_in = r_dut_in;
        w_tt     = r_tt;
        w_uns    = r_uns;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state  = ST_SETTLE;
                    w_cnt    = {CNT_W{1'b0}};
                    w_vec    = {IN_WIDTH{1'b0}};
                    w_dut_in = {IN_WIDTH{1'b0}};
                    w_tt     = {DEPTH{1'b0}};
                    w_uns    = {DEPTH{1'b0}};
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_state = ST_SAMPLE;
                    w_cnt   = {CNT_W{1'b0}};
                    w_ones  = {ONES_W{1'b0}};
                end else begin
                    w_cnt = r_cnt + CNT_W'(1'b1);
                end
            end
            ST_SAMPLE: begin
                // At most SAMPLES increments, so the counter cannot wrap.
                w_ones = r_ones + ONES_W'(w_sync);
                if (r_cnt == SAMPLE_LAST) begin
                    w_state = ST_STORE;
                    w_cnt   = {CNT_W{1'b0}};
                end else begin
                    w_cnt = r_cnt + CNT_W'(1'b1);
                end
            end
            ST_STORE: begin
                w_tt[r_vec]  = w_majority;
                w_uns[r_vec] = w_mixed;
                if (r_vec == VEC_LAST) begin
                    w_state  = ST_DONE;
                    w_dut_in = {IN_WIDTH{1'b0}};
                end else begin
                    w_state  = ST_SETTLE;
                    w_vec    = r_vec + IN_WIDTH'(1'b1);
                    w_dut_in = r_vec + IN_WIDTH'(1'b1);
                end
            end
            ST_DONE: begin
                w_state  = ST_IDLE;
                w_dut_in = {IN_WIDTH{1'b0}};
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        w_busy = (w_state == ST_SETTLE) || (w_state == ST_SAMPLE) || (w_state == ST_STORE);
        w_done = (w_state == ST_DONE);
    end

    // State and datapath registers; outputs are registered copies of next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= {CNT_W{1'b0}};
            r_ones   <= {ONES_W{1'b0}};
            r_vec    <= {IN_WIDTH{1'b0}};
            r_dut_in <= {IN_WIDTH{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_tt     <= {DEPTH{1'b0}};
            r_uns    <= {DEPTH{1'b0}};
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_ones   <= w_ones;
            r_vec    <= w_vec;
            r_dut_in <= w_dut_in;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_tt     <= w_tt;
            r_uns    <= w_uns;
        end
    end

    assign bus.dut_in      = r_dut_in;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.truth_table = r_tt;
    assign bus.unstable    = r_uns;

endmodule

// File: tb/tb_tpl_sweep_ctrl.sv
// Bench for tpl_sweep_ctrl: an 8-periodic behavioural CUT per vector, compared
// against a popcount-based majority/instability model.
module tb_tpl_sweep_ctrl;
    import tpl_test_pkg::*;

    localparam int S_A = 16;
    localparam int N_A = 8;
    localparam int S_B = 3;
    localparam int N_B = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tpl_sweep_ctrl_if #(.IN_WIDTH(4)) ifa ();
    tpl_sweep_ctrl_if #(.IN_WIDTH(4)) ifb ();

    tpl_sweep_ctrl #(.IN_WIDTH(4), .SETTLE_CYCLES(S_A), .SAMPLES(N_A)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.master)
    );

    tpl_sweep_ctrl #(.IN_WIDTH(4), .SETTLE_CYCLES(S_B), .SAMPLES(N_B)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Per-vector output pattern, replayed with period 8 (= N_A), so any window
    // of 8 consecutive samples sees exactly popcount(pattern) ones.
    logic [7:0] pat [16] = '{default: 8'h00};
    logic [3:0] hist [5] = '{default: 4'd0};
    int         phase = 0;

    // Behavioural CUT: 5-cycle input-to-output delay plus the periodic pattern.
    always @(negedge clk) begin
        ifa.dut_out = pat[hist[4]][phase];
        for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = ifa.dut_in;
        phase = (phase + 1) % 8;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(output logic [15:0] tt, output logic [15:0] un);
        int pc;
        for (int v = 0; v < 16; v++) begin
            pc = $countones(pat[v]);
            tt[v] = (2 * pc > N_A);
            un[v] = (pc != 0) && (pc != N_A);
        end
    endtask

    task automatic set_start(input bit sel_b, input logic val);
        if (sel_b) ifb.start = val;
        else       ifa.start = val;
    endtask

    // Runs one sweep; cycle 1 is the cycle right after the edge that sees start.
    task automatic sweep(input bit sel_b, input bit hold,
                         output int busy_cyc, output int done_at,
                         output int done_cnt, output logic [3:0] done_din);
        logic b, d;
        busy_cyc = 0; done_at = 0; done_cnt = 0; done_din = 4'hx;
        @(negedge clk);
        set_start(sel_b, 1'b1);
        @(negedge clk);
        for (int cyc = 1; cyc <= 1000; cyc++) begin
            b = sel_b ? ifb.busy : ifa.busy;
            d = sel_b ? ifb.done : ifa.done;
            if (b) busy_cyc++;
            if (d) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at  = cyc;
                    done_din = sel_b ? ifb.dut_in : ifa.dut_in;
                end
            end
            if (!hold || (done_at != 0 && cyc > done_at)) set_start(sel_b, 1'b0);
            if (done_at != 0 && cyc >= done_at + 20) break;
            @(negedge clk);
        end
        set_start(sel_b, 1'b0);
    endtask

    task automatic xor_pattern();
        for (int v = 0; v < 16; v++) pat[v] = (^v[3:0]) ? 8'hFF : 8'h00;
    endtask

    task automatic check_sweep(input string tag);
        logic [15:0] et, eu;
        int bc, da, dc;
        logic [3:0] dd;
        model(et, eu);
        sweep(1'b0, 1'b0, bc, da, dc, dd);
        check({tag, "_tt"}, ifa.truth_table, et);
        check({tag, "_uns"}, ifa.unstable, eu);
        check({tag, "_busy"}, bc, 400);
        check({tag, "_done_at"}, da, 401);
    endtask

    initial begin
        int bc, da, dc;
        logic [3:0] dd;
        logic [15:0] et, eu;
        bit found;

        reset = 1'b1;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        ifb.dut_out = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dut_in", ifa.dut_in, 0);
        check("rst_busy", ifa.busy, 0);
        check("rst_done", ifa.done, 0);
        check("rst_tt", ifa.truth_table, 0);
        check("rst_uns", ifa.unstable, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // XOR CUT, full timing check.
        xor_pattern();
        model(et, eu);
        check("xor_model", et, 16'h6996);
        sweep(1'b0, 1'b0, bc, da, dc, dd);
        check("xor_tt", ifa.truth_table, 16'h6996);
        check("xor_uns", ifa.unstable, 16'h0000);
        check("xor_busy", bc, 400);
        check("xor_done_at", da, 401);
        check("xor_done_cnt", dc, 1);
        check("xor_done_din", dd, 0);

        // Output toggling every clock: 4 of 8 is a tie.
        for (int v = 0; v < 16; v++) pat[v] = 8'h55;
        sweep(1'b0, 1'b0, bc, da, dc, dd);
        check("tog_tt", ifa.truth_table, 16'h0000);
        check("tog_uns", ifa.unstable, 16'hFFFF);

        // One only for vector 15, 5-of-8 on vector 3.
        for (int v = 0; v < 16; v++) pat[v] = 8'h00;
        pat[15] = 8'hFF;
        pat[3]  = 8'b1011_0101;
        sweep(1'b0, 1'b0, bc, da, dc, dd);
        check("v15_tt", ifa.truth_table, 16'h8008);
        check("v15_uns", ifa.unstable, 16'h0008);

        // Randomized CUT behaviours against the popcount model.
        for (int r = 0; r < 4; r++) begin
            for (int v = 0; v < 16; v++) begin
                case ($urandom_range(0, 3))
                    0:       pat[v] = 8'h00;
                    1:       pat[v] = 8'hFF;
                    default: pat[v] = 8'($urandom);
                endcase
            end
            check_sweep($sformatf("rnd%0d", r));
        end

        // Start held high through the sweep and through DONE.
        xor_pattern();
        sweep(1'b0, 1'b1, bc, da, dc, dd);
        check("hold_busy", bc, 400);
        check("hold_done_cnt", dc, 1);
        check("hold_done_at", da, 401);
        check("hold_idle_busy", ifa.busy, 0);

        // Reset while sampling vector 7.
        @(negedge clk);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            if (ifa.dut_in == 4'd7) found = 1'b1;
            else @(negedge clk);
        end
        check("rst7_reach", found, 1);
        repeat (S_A + 2) @(negedge clk);
        check("rst7_partial_tt", ifa.truth_table, 16'h0016);
        check("rst7_busy", ifa.busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst7_dut_in", ifa.dut_in, 0);
        check("rst7_busy0", ifa.busy, 0);
        check("rst7_done", ifa.done, 0);
        check("rst7_tt", ifa.truth_table, 0);
        check("rst7_uns", ifa.unstable, 0);
        repeat (3) @(negedge clk);
        check("rst7_idle", ifa.busy, 0);
        check_sweep("after_rst");

        // Stuck-at-1 CUT with minimal settle and a single sample.
        sweep(1'b1, 1'b0, bc, da, dc, dd);
        check("b_tt", ifb.truth_table, 16'hFFFF);
        check("b_uns", ifb.unstable, 16'h0000);
        check("b_busy", bc, 16 * (S_B + N_B + 1));
        check("b_done_at", da, 16 * (S_B + N_B + 1) + 1);
        check("b_done_cnt", dc, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
